// File: rtl/char_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : char_feeder_if
//  Purpose  : Bundles the producer handshake, the recognizer character bus
//             and the occupancy/status outputs of char_feeder.
//  Modports : master - producer/consumer side (drives in_char, in_valid,
//                      pop_en; observes everything else)
//             slave  - the feeder itself
//  Signals  : in_char[7:0], in_valid, in_ready   producer handshake
//             pop_en                              consumer drain permission
//             char[7:0], char_valid, cls[1:0]     registered output character
//             count, full, empty, drop_cnt[7:0]   status
//  Revision : 1.0 - initial release
// ============================================================================
interface char_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int c_cw = $clog2(DEPTH) + 1;

  logic [7:0]      in_char;
  logic            in_valid;
  logic            in_ready;
  logic            pop_en;
  logic [7:0]      char;
  logic            char_valid;
  logic [1:0]      cls;
  logic [c_cw-1:0] count;
  logic            full;
  logic            empty;
  logic [7:0]      drop_cnt;

  modport master (
    output in_char, in_valid, pop_en,
    input  in_ready, char, char_valid, cls, count, full, empty, drop_cnt
  );

  modport slave (
    input  in_char, in_valid, pop_en,
    output in_ready, char, char_valid, cls, count, full, empty, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/char_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : char_feeder
//  Purpose  : Small circular FIFO between an ASCII character producer and the
//             identifier-recognition FSM. Drains at most one character per
//             clock onto a registered 8-bit bus, tagged with a registered
//             class code (01 letter, 10 digit, 00 other). Emits FILL_CHAR
//             with char_valid low whenever nothing is popped.
//  Ports    : clk    - sole clock, rising edge
//             reset  - asynchronous, active-high; clears pointers, count,
//                      outputs and drop counter (storage is not cleared)
//             bus    - char_feeder_if.slave (handshake, output bus, status)
//  Revision : 1.0 - initial release
// ============================================================================
module char_feeder #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] FILL_CHAR = 8'd0
) (
  input  logic         clk,
  input  logic         reset,
  char_feeder_if.slave bus
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);
  localparam logic [7:0]      c_drop_max  = 8'd255;

  // Letter / digit / other decode of an ASCII byte.
  function automatic logic [1:0] f_class(input logic [7:0] c);
    logic [1:0] r;
    r = 2'b00;
    if ((c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122))
      r = 2'b01;
    else if (c >= 8'd48 && c <= 8'd57)
      r = 2'b10;
    return r;
  endfunction

  localparam logic [1:0] c_fill_cls = f_class(FILL_CHAR);

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wp;
  logic [c_aw-1:0] r_rp;
  logic [c_cw-1:0] r_count;
  logic [7:0]      r_char;
  logic            r_char_valid;
  logic [1:0]      r_cls;
  logic [7:0]      r_drop_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [7:0]      w_head;

  // Status is decoded from the registered count only, so a pop in the
  // same cycle never opens a slot for a push (no full-bypass), and a push
  // into an empty FIFO is never popped in the same cycle (no empty-bypass).
  assign w_full     = (r_count == c_depth_cnt);
  assign w_empty    = (r_count == '0);
  assign w_in_ready = !w_full;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = bus.pop_en && !w_empty;
  assign w_drop     = bus.in_valid && !w_in_ready;
  assign w_head     = r_mem[r_rp];

  // Storage is deliberately left out of reset; pointers guard stale data.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= bus.in_char;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_char       <= FILL_CHAR;
      r_cls        <= c_fill_cls;
      r_char_valid <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end

      if (w_pop) begin
        r_rp         <= r_rp + c_ptr_one;
        r_char       <= w_head;
        r_cls        <= f_class(w_head);
        r_char_valid <= 1'b1;
      end else begin
        r_char       <= FILL_CHAR;
        r_cls        <= c_fill_cls;
        r_char_valid <= 1'b0;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase

      // Saturate rather than wrap so a long overload stays visible.
      if (w_drop && (r_drop_cnt != c_drop_max)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.char       = r_char;
  assign bus.char_valid = r_char_valid;
  assign bus.cls        = r_cls;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_char_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_char_feeder
//  Purpose  : Directed self-checking bench for char_feeder (DEPTH 8,
//             FILL_CHAR 0). Inputs change 1 ns after a rising edge and
//             outputs are checked there as well.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_char_feeder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  char_feeder_if #(.DEPTH(8)) bus ();

  char_feeder #(
    .DEPTH     (8),
    .FILL_CHAR (8'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus and land 1 ns after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] c, input logic p);
    bus.in_valid = v;
    bus.in_char  = c;
    bus.pop_en   = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    logic       exp_vld [5];
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'd0;
    bus.pop_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ---- asynchronous reset between edges ----
    cyc(1'b1, 8'd65, 1'b0);
    cyc(1'b1, 8'd66, 1'b1);
    chk("pre_rst_char", bus.char, 8'd65);
    chk("pre_rst_valid", bus.char_valid, 1'b1);
    cyc(1'b0, 8'd0, 1'b0);  // char drops to fill, count stays 1
    bus.pop_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_char", bus.char, 8'd0);
    chk("rst_valid", bus.char_valid, 1'b0);
    chk("rst_cls", bus.cls, 2'b00);
    chk("rst_count", bus.count, 4'd0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_drop", bus.drop_cnt, 8'd0);
    #1 reset = 1'b0;

    // ---- in-order drain ----
    cyc(1'b1, 8'd97, 1'b0);
    cyc(1'b1, 8'd98, 1'b0);
    cyc(1'b1, 8'd99, 1'b0);
    cyc(1'b1, 8'd100, 1'b0);
    chk("drain_count4", bus.count, 4'd4);
    chk("drain_hold_valid", bus.char_valid, 1'b0);
    exp_seq = '{8'd97, 8'd98, 8'd99, 8'd100, 8'd0};
    exp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'd0, 1'b1);
      chk("drain_char", bus.char, exp_seq[i]);
      chk("drain_valid", bus.char_valid, exp_vld[i]);
      chk("drain_cls", bus.cls, (i < 4) ? 2'b01 : 2'b00);
    end
    chk("drain_count0", bus.count, 4'd0);

    // ---- overflow ----
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 8'(49 + i), 1'b0);
      if (i == 7) begin
        chk("ovf_full", bus.full, 1'b1);
        chk("ovf_ready", bus.in_ready, 1'b0);
        chk("ovf_drop0", bus.drop_cnt, 8'd0);
      end
    end
    chk("ovf_drop1", bus.drop_cnt, 8'd1);
    chk("ovf_count", bus.count, 4'd8);
    // Full with pop and offer together: offer rejected, count 7.
    cyc(1'b1, 8'd88, 1'b1);
    chk("fullpop_char", bus.char, 8'd49);
    chk("fullpop_cls", bus.cls, 2'b10);
    chk("fullpop_count", bus.count, 4'd7);
    chk("fullpop_drop", bus.drop_cnt, 8'd2);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 8'd0, 1'b1);
      chk("ovf_char", bus.char, 8'(49 + i));
      chk("ovf_cls", bus.cls, 2'b10);
    end
    cyc(1'b0, 8'd0, 1'b1);
    chk("ovf_tail_valid", bus.char_valid, 1'b0);
    chk("ovf_tail_char", bus.char, 8'd0);
    chk("ovf_empty", bus.empty, 1'b1);

    // ---- push and pop together at count 3 ----
    cyc(1'b1, 8'd104, 1'b0);
    cyc(1'b1, 8'd105, 1'b0);
    cyc(1'b1, 8'd106, 1'b0);
    cyc(1'b1, 8'd47, 1'b1);
    chk("pp_count", bus.count, 4'd3);
    chk("pp_char", bus.char, 8'd104);
    cyc(1'b0, 8'd0, 1'b1);
    chk("pp_char1", bus.char, 8'd105);
    cyc(1'b0, 8'd0, 1'b1);
    chk("pp_char2", bus.char, 8'd106);
    cyc(1'b0, 8'd0, 1'b1);
    chk("pp_char3", bus.char, 8'd47);
    chk("pp_cls3", bus.cls, 2'b00);
    chk("pp_valid3", bus.char_valid, 1'b1);
    chk("pp_count0", bus.count, 4'd0);

    // ---- wrap-around streaming: 20 push/pop cycles ----
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(65 + i), 1'b1);
      if (i == 0) begin
        chk("wrap_first_valid", bus.char_valid, 1'b0);
      end else begin
        chk("wrap_char", bus.char, 8'(65 + i - 1));
        chk("wrap_valid", bus.char_valid, 1'b1);
      end
      chk("wrap_count", bus.count, 4'd1);
    end
    cyc(1'b0, 8'd0, 1'b1);
    chk("wrap_last", bus.char, 8'd84);
    chk("wrap_count0", bus.count, 4'd0);

    // ---- mid-stream reset ----
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(70 + i), 1'b0);
    chk("mid_count5", bus.count, 4'd5);
    chk("mid_drop", bus.drop_cnt, 8'd2);
    bus.in_valid = 1'b0;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    chk("mid_rst_count", bus.count, 4'd0);
    chk("mid_rst_drop", bus.drop_cnt, 8'd0);
    cyc(1'b1, 8'd120, 1'b0);
    chk("mid_push_char", bus.char, 8'd0);
    chk("mid_push_count", bus.count, 4'd1);
    cyc(1'b0, 8'd0, 1'b1);
    chk("mid_pop_char", bus.char, 8'd120);
    chk("mid_pop_valid", bus.char_valid, 1'b1);
    cyc(1'b0, 8'd0, 1'b1);
    chk("mid_no_stale_valid", bus.char_valid, 1'b0);
    chk("mid_no_stale_char", bus.char, 8'd0);

    // ---- drop counter saturation ----
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd33, 1'b0);
    for (int i = 0; i < 255; i++) cyc(1'b1, 8'd33, 1'b0);
    chk("sat_255", bus.drop_cnt, 8'd255);
    cyc(1'b1, 8'd33, 1'b0);
    chk("sat_hold", bus.drop_cnt, 8'd255);
    chk("sat_count", bus.count, 4'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
